// File: rtl/cmd_latch_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_latch_encoder_if                                               |
// | Button / command handshake bundle between the encoder and counter. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface cmd_latch_encoder_if #(
   parameter int N_CH   = 3,
   parameter int CODE_W = 2
);
   logic [N_CH-1:0]   btn;
   logic              cmd_ack;
   logic              clr_pending;
   logic              cmd_valid;
   logic [CODE_W-1:0] cmd_code;
   logic [N_CH-1:0]   pending;
   logic              drop_pulse;

   modport master (
      output btn, cmd_ack, clr_pending,
      input  cmd_valid, cmd_code, pending, drop_pulse
   );

   modport slave (
      input  btn, cmd_ack, clr_pending,
      output cmd_valid, cmd_code, pending, drop_pulse
   );
endinterface
`default_nettype wire

// File: rtl/cmd_latch_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_latch_encoder                                                  |
// | Debounced buttons -> sticky requests -> one held priority command. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cmd_latch_encoder #(
   parameter int N_CH         = 3,
   parameter int CODE_W       = 2,
   parameter int DEBOUNCE_CYC = 4,
   parameter int PREEMPT      = 1
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   cmd_latch_encoder_if.slave  bus
);
   localparam int              CNT_W      = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   logic [N_CH-1:0]   r_s1;
   logic [N_CH-1:0]   r_s2;
   logic [N_CH-1:0]   w_db;
   logic [N_CH-1:0]   r_db_prev;
   logic [N_CH-1:0]   r_pending;
   logic              r_valid;
   logic              r_drop;
   logic [CODE_W-1:0] r_code;
   state_t            r_state;

   logic [N_CH-1:0]   w_press;
   logic [N_CH-1:0]   w_take;
   logic [N_CH-1:0]   w_requeue;
   logic              w_preempt;
   logic              w_any;
   logic [CODE_W-1:0] w_k;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= bus.btn;
         r_s2 <= r_s1;
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_db
         logic [CNT_W-1:0] r_cnt;
         logic             r_db;

         // Level flips on the DEBOUNCE_CYC-th consecutive mismatching cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
               r_db  <= 1'b0;
            end else if (r_s2[gi] == r_db) begin
               r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
               r_cnt <= '0;
               r_db  <= r_s2[gi];
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_db[gi] = r_db;
      end
   endgenerate

   assign w_press = w_db & ~r_db_prev;

   // Descending scan leaves the lowest set index in w_k.
   always_comb begin
      w_k   = '0;
      w_any = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_k   = CODE_W'(i);
            w_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_take    = '0;
      w_requeue = '0;
      w_preempt = 1'b0;
      if (r_state == ST_IDLE) begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_any && (CODE_W'(i) == w_k)) w_take[i] = 1'b1;
         end
      end else if (!bus.cmd_ack && (PREEMPT != 0) && (r_code != CODE_W'(1)) && r_pending[0]) begin
         w_preempt = 1'b1;
         w_take[0] = 1'b1;
         for (int i = 0; i < N_CH; i++) begin
            if (CODE_W'(i + 1) == r_code) w_requeue[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db_prev <= '0;
         r_pending <= '0;
         r_drop    <= 1'b0;
      end else begin
         r_db_prev <= w_db;
         r_pending <= (r_pending & ~w_take & ~{N_CH{bus.clr_pending}}) | w_press | w_requeue;
         r_drop    <= |(w_press & r_pending & ~w_take);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_code  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_HOLD;
                  r_valid <= 1'b1;
                  r_code  <= w_k + 1'b1;
               end else begin
                  r_valid <= 1'b0;
                  r_code  <= '0;
               end
            end
            ST_HOLD: begin
               if (bus.cmd_ack) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_code  <= '0;
               end else if (w_preempt) begin
                  r_code <= CODE_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_code  <= '0;
            end
         endcase
      end
   end

   assign bus.cmd_valid  = r_valid;
   assign bus.cmd_code   = r_code;
   assign bus.pending    = r_pending;
   assign bus.drop_pulse = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_cmd_latch_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cmd_latch_encoder                                               |
// | Directed and random stimulus against a cycle reference model.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cmd_latch_encoder;
   localparam int N_CH = 3;
   localparam int CODE_W = 2;
   localparam int DB = 4;
   localparam int PRE = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   drop_cnt = 0;
   int   n;

   cmd_latch_encoder_if #(.N_CH(N_CH), .CODE_W(CODE_W)) bus ();

   cmd_latch_encoder #(
      .N_CH(N_CH), .CODE_W(CODE_W), .DEBOUNCE_CYC(DB), .PREEMPT(PRE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference state: levels as bit vectors, held command as a channel number (-1 = none).
   logic [N_CH-1:0] m_s1, m_s2, m_db, m_dbp, m_pend;
   int              m_held;
   bit              m_drop;
   bit              m_hist[N_CH][$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0; m_pend = '0;
      m_held = -1; m_drop = 1'b0;
      for (int i = 0; i < N_CH; i++) m_hist[i].delete();
   endtask

   task automatic step();
      logic [N_CH-1:0] press, fclr, fset, pend_n, db_n;
      int held_n;
      bit diff;
      press = m_db & ~m_dbp;
      fclr = '0; fset = '0; held_n = m_held;
      if (m_held < 0) begin
         for (int i = N_CH - 1; i >= 0; i--) if (m_pend[i]) held_n = i;
         if (held_n >= 0) fclr[held_n] = 1'b1;
      end else if (bus.cmd_ack) begin
         held_n = -1;
      end else if (PRE != 0 && m_held != 0 && m_pend[0]) begin
         held_n = 0; fset[m_held] = 1'b1; fclr[0] = 1'b1;
      end
      pend_n = (m_pend & ~fclr & ~{N_CH{bus.clr_pending}}) | press | fset;
      m_drop = |(press & m_pend & ~fclr);
      db_n = m_db;
      // A level changes once the last DB synchronised samples all disagree with it.
      for (int i = 0; i < N_CH; i++) begin
         m_hist[i].push_back(m_s2[i]);
         if (m_hist[i].size() > DB) void'(m_hist[i].pop_front());
         diff = (m_hist[i].size() == DB);
         for (int j = 0; j < m_hist[i].size(); j++) if (m_hist[i][j] == m_db[i]) diff = 1'b0;
         if (diff) db_n[i] = m_s2[i];
      end
      m_dbp = m_db; m_db = db_n; m_s2 = m_s1; m_s1 = bus.btn;
      m_pend = pend_n; m_held = held_n;
      @(posedge clk);
      #1;
      chk("cmd_valid", bus.cmd_valid, (m_held >= 0) ? 1 : 0);
      chk("cmd_code", bus.cmd_code, (m_held >= 0) ? m_held + 1 : 0);
      chk("pending", bus.pending, m_pend);
      chk("drop_pulse", bus.drop_pulse, m_drop);
      if (bus.drop_pulse) drop_cnt++;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic press(input int ch);
      bus.btn[ch] = 1'b1; steps(8);
      bus.btn[ch] = 1'b0; steps(8);
   endtask

   task automatic wait_valid(input int maxc, output int cnt);
      cnt = 0;
      while (!bus.cmd_valid && cnt < maxc) begin step(); cnt++; end
      chk("wait_valid", bus.cmd_valid, 1);
   endtask

   task automatic ack_once();
      bus.cmd_ack = 1'b1; step(); bus.cmd_ack = 1'b0;
   endtask

   initial begin
      bus.btn = '0; bus.cmd_ack = 1'b0; bus.clr_pending = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.cmd_valid, 0);
      chk("rst_code", bus.cmd_code, 0);
      chk("rst_pending", bus.pending, 0);
      chk("rst_drop", bus.drop_pulse, 0);
      rst_n = 1'b1;
      steps(3);

      // Single press with absolute latency.
      bus.btn = 3'b010;
      for (int e = 1; e <= 13; e++) begin
         if (e == 11) bus.btn = '0;
         bus.cmd_ack = (e == 12);
         step();
         if (e == 7) begin
            chk("single_pend7", bus.pending, 3'b010);
            chk("single_valid7", bus.cmd_valid, 0);
         end
         if (e == 8) begin
            chk("single_valid8", bus.cmd_valid, 1);
            chk("single_code8", bus.cmd_code, 2);
         end
         if (e == 13) begin
            chk("single_valid13", bus.cmd_valid, 0);
            chk("single_code13", bus.cmd_code, 0);
         end
      end
      bus.cmd_ack = 1'b0;
      steps(10);

      // Glitch shorter than the debounce window.
      bus.btn[2] = 1'b1; steps(3);
      bus.btn[2] = 1'b0; steps(12);
      chk("glitch_pending", bus.pending, 0);
      chk("glitch_valid", bus.cmd_valid, 0);

      // Simultaneous presses: channel 1 first, channel 2 after an idle gap.
      bus.btn = 3'b110; steps(8);
      bus.btn = '0;
      wait_valid(30, n);
      chk("prio_first", bus.cmd_code, 2);
      ack_once();
      wait_valid(30, n);
      chk("prio_second", bus.cmd_code, 3);
      chk("prio_gap", (n >= 1) ? 1 : 0, 1);
      ack_once();
      steps(10);

      // Drop: second press of an already pending channel.
      bus.btn[0] = 1'b1; steps(8); bus.btn[0] = 1'b0;
      wait_valid(30, n);
      chk("drop_hold_code", bus.cmd_code, 1);
      drop_cnt = 0;
      press(2);
      press(2);
      chk("drop_count", drop_cnt, 1);
      chk("drop_pending2", bus.pending[2], 1);
      ack_once();
      wait_valid(30, n);
      chk("drop_served", bus.cmd_code, 3);
      ack_once();
      steps(10);

      // Pre-emption of a held lower-priority command.
      bus.btn[2] = 1'b1; steps(8); bus.btn[2] = 1'b0;
      wait_valid(30, n);
      chk("pre_hold3", bus.cmd_code, 3);
      press(0);
      chk("pre_code1", bus.cmd_code, 1);
      chk("pre_valid", bus.cmd_valid, 1);
      chk("pre_requeue", bus.pending[2], 1);
      ack_once();
      wait_valid(30, n);
      chk("pre_after", bus.cmd_code, 3);
      ack_once();
      steps(10);

      // Asynchronous reset while holding.
      bus.btn = 3'b110; steps(8); bus.btn = '0;
      wait_valid(30, n);
      chk("rh_code", bus.cmd_code, 2);
      chk("rh_pending", bus.pending, 3'b100);
      rst_n = 1'b0;
      #2;
      chk("rh_valid0", bus.cmd_valid, 0);
      chk("rh_code0", bus.cmd_code, 0);
      chk("rh_pend0", bus.pending, 0);
      chk("rh_drop0", bus.drop_pulse, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      steps(15);
      chk("rh_quiet", bus.cmd_valid, 0);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N_CH; i++)
            if ($urandom_range(0, 11) == 0) bus.btn[i] = ~bus.btn[i];
         bus.cmd_ack     = ($urandom_range(0, 3) == 0);
         bus.clr_pending = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
